// File: rtl/rx_ram_writer_pkg.sv
// Shared definitions for the UART receive-to-RAM capture block.
// Capture states and the string terminator byte live here.
package rx_ram_writer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t CAPTURE = 2'd0;
  localparam state_t TERM    = 2'd1;
  localparam state_t FULL    = 2'd2;

  localparam logic [7:0] TERM_BYTE = 8'h00;

  function automatic logic is_done(input state_t s);
    return (s != CAPTURE);
  endfunction

endpackage

// File: rtl/rx_ram_writer_if.sv
// Bundle between a byte receiver, the capture block and its external RAM.
// master drives received bytes and re-arm; slave is the capture block.
interface rx_ram_writer_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);

  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  clear;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH:0]   count;
  logic                  done;
  logic                  overflow;

  modport master (
    output rx_ready, rx_data, clear,
    input  wr_en, wr_addr, wr_data, count, done, overflow
  );

  modport slave (
    input  rx_ready, rx_data, clear,
    output wr_en, wr_addr, wr_data, count, done, overflow
  );

endinterface

// File: rtl/rx_ram_writer.sv
// Stores bytes from a UART receiver into an external RAM until it is full.
// Define RX_RAM_WRITER_TERM_EN to also stop capture after storing a 0x00 byte.
module rx_ram_writer
  import rx_ram_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  rx_ram_writer_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0] ONE      = 1;
  localparam logic [ADDR_WIDTH:0] CAPACITY = ONE << ADDR_WIDTH;

  state_t                state;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  overflow_q;
  logic [ADDR_WIDTH:0]   count_inc;

  assign count_inc = count_q + ONE;

  // The write, count update and state change all land on the edge that
  // samples the strobe, so done rises together with the final wr_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CAPTURE;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (bus.clear) begin
      state      <= CAPTURE;
      wr_en_q    <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state)
        CAPTURE: begin
          if (bus.rx_ready) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= count_q[ADDR_WIDTH-1:0];
            wr_data_q <= bus.rx_data;
            count_q   <= count_inc;
            if (count_inc == CAPACITY) begin
              state <= FULL;
            end
`ifdef RX_RAM_WRITER_TERM_EN
            else if (bus.rx_data == DATA_WIDTH'(TERM_BYTE)) begin
              state <= TERM;
            end
`endif
          end
        end
        FULL: begin
          if (bus.rx_ready) begin
            overflow_q <= 1'b1;
          end
        end
        TERM: begin
        end
        default: begin
          state <= CAPTURE;
        end
      endcase
    end
  end

  // Reset suppresses a write still in flight from the previous strobe.
  assign bus.wr_en    = wr_en_q & ~rst;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.count    = count_q;
  assign bus.done     = is_done(state);
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_rx_ram_writer.sv
// Scoreboard bench for rx_ram_writer with a 4-byte RAM (ADDR_WIDTH=2).
// Expected writes are queued at stimulus time and popped by a wr_en monitor.
module tb_rx_ram_writer;

  localparam int AW = 2;
  localparam int DW = 8;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
    logic [31:0] cnt;
    logic [31:0] done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t expQ[$];
  exp_t mon;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  rx_ram_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rx_ram_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One strobe; when a write is expected it must appear on the very next cycle.
  task automatic applyStimulus(input logic [7:0] data, input bit expWrite,
                               input int expAddr, input bit expDone);
    bus.rx_ready = 1'b1;
    bus.rx_data  = data;
    if (expWrite)
      expQ.push_back('{32'(expAddr), 32'(data), 32'(cyc + 1), 32'(expAddr + 1), 32'(expDone)});
    tick();
    bus.rx_ready = 1'b0;
  endtask

  task automatic pulseClear(input bit withStrobe, input logic [7:0] data);
    bus.clear    = 1'b1;
    bus.rx_ready = withStrobe;
    bus.rx_data  = data;
    tick();
    bus.clear    = 1'b0;
    bus.rx_ready = 1'b0;
  endtask

  task automatic checkIdle(input string tag, input int cnt, input bit dn, input bit ovf);
    checkOutput({tag, "_count"}, 32'(bus.count), 32'(cnt));
    checkOutput({tag, "_done"}, 32'(bus.done), 32'(dn));
    checkOutput({tag, "_overflow"}, 32'(bus.overflow), 32'(ovf));
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0 && expQ[0].cyc < 32'(cyc)) begin
      mon = expQ.pop_front();
      checkOutput("missing_wr_en", 32'(0), mon.data);
    end
    if (bus.wr_en !== 1'b0) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_wr_en", 32'(bus.wr_en), 32'(0));
      end else begin
        mon = expQ.pop_front();
        checkOutput("wr_cycle", 32'(cyc), mon.cyc);
        checkOutput("wr_addr", 32'(bus.wr_addr), mon.addr);
        checkOutput("wr_data", 32'(bus.wr_data), mon.data);
        checkOutput("wr_count", 32'(bus.count), mon.cnt);
        checkOutput("wr_done", 32'(bus.done), mon.done);
      end
    end
  end

  initial begin
    bus.rx_ready = 1'b0;
    bus.rx_data  = '0;
    bus.clear    = 1'b0;
    rst          = 1'b1;
    tick(2);
    rst = 1'b0;
    tick();
    checkOutput("rst_wr_en", 32'(bus.wr_en), 32'(0));
    checkOutput("rst_wr_addr", 32'(bus.wr_addr), 32'(0));
    checkOutput("rst_wr_data", 32'(bus.wr_data), 32'(0));
    checkIdle("rst", 0, 1'b0, 1'b0);

    // Two bytes four cycles apart
    applyStimulus(8'h48, 1'b1, 0, 1'b0);
    tick(3);
    applyStimulus(8'h69, 1'b1, 1, 1'b0);
    tick(3);
    checkIdle("two_bytes", 2, 1'b0, 1'b0);

    // Clear coincident with a strobe drops that byte
    applyStimulus(8'h33, 1'b1, 2, 1'b0);
    tick();
    pulseClear(1'b1, 8'h55);
    checkOutput("clear_no_wr_en", 32'(bus.wr_en), 32'(0));
    checkIdle("clear", 0, 1'b0, 1'b0);
    applyStimulus(8'h66, 1'b1, 0, 1'b0);
    tick(2);
    checkIdle("after_clear", 1, 1'b0, 1'b0);

`ifdef RX_RAM_WRITER_TERM_EN
    pulseClear(1'b0, 8'h00);
    applyStimulus(8'h41, 1'b1, 0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1, 1'b1);
    tick();
    applyStimulus(8'h42, 1'b0, 0, 1'b0);
    tick(2);
    checkIdle("term", 2, 1'b1, 1'b0);
`endif

    // Back-to-back bytes past capacity
    pulseClear(1'b0, 8'h00);
    for (int i = 0; i < 6; i++)
      applyStimulus(8'(8'h10 + i), i < 4, i, i == 3);
    tick(2);
    checkIdle("full", 4, 1'b1, 1'b1);
    pulseClear(1'b0, 8'h00);
    checkIdle("full_clear", 0, 1'b0, 1'b0);

    // Reset in the cycle after a strobe cancels its write
    applyStimulus(8'hAA, 1'b0, 0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("rst_inflight_wr_en", 32'(bus.wr_en), 32'(0));
    tick();
    rst = 1'b0;
    checkOutput("rst2_wr_en", 32'(bus.wr_en), 32'(0));
    checkOutput("rst2_wr_addr", 32'(bus.wr_addr), 32'(0));
    checkOutput("rst2_wr_data", 32'(bus.wr_data), 32'(0));
    checkIdle("rst2", 0, 1'b0, 1'b0);
    applyStimulus(8'h77, 1'b1, 0, 1'b0);
    tick(3);
    checkIdle("after_rst", 1, 1'b0, 1'b0);

    checkOutput("queue_drained", 32'(expQ.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_ram_writer.md
RX_RAM_WRITER -- requirements
Module: rx_ram_writer

Interface
REQ-001 Parameter: ADDR_WIDTH, default 5, RAM address width in bits; capacity 2**ADDR_WIDTH bytes.
REQ-002 Parameter: DATA_WIDTH, default 8, byte width; SHALL equal the uart_rx DATA_WIDTH.
REQ-003 Port: clk  input  1  single clock; all logic on posedge clk.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: rx_ready  input  1  one-cycle strobe from uart_rx; rx_data is valid in that cycle.
REQ-006 Port: rx_data  input  DATA_WIDTH  received byte.
REQ-007 Port: clear  input  1  one-cycle re-arm request.
REQ-008 Port: wr_en  output  1  RAM write strobe.
REQ-009 Port: wr_addr  output  ADDR_WIDTH  RAM write address.
REQ-010 Port: wr_data  output  DATA_WIDTH  RAM write data.
REQ-011 Port: count  output  ADDR_WIDTH+1  bytes stored since the last arm.
REQ-012 Port: done  output  1  capture finished; level.
REQ-013 Port: overflow  output  1  sticky: a byte arrived while FULL.

Function
REQ-014 FSM states: CAPTURE, TERM, FULL.
- Reset and clear both enter CAPTURE.
REQ-015 In CAPTURE, a rx_ready strobe with a storable byte drives the write on the next cycle:
- wr_en=1 for exactly one cycle.
- wr_addr=count (old value), wr_data=rx_data.
- count increments in that same cycle.
REQ-016 Write latency is exactly 1 cycle from rx_ready to wr_en; back-to-back strobes on consecutive cycles are all written.
REQ-017 When count reaches 2**ADDR_WIDTH, the FSM enters FULL and done=1 in the same cycle as the last wr_en.
REQ-018 In FULL and TERM:
- rx_ready produces no write.
- count holds.
- In FULL only, rx_ready sets overflow=1, which holds until reset or clear.
REQ-019 done=1 in TERM and FULL, 0 in CAPTURE.
REQ-020 clear in any state, including the cycle of a rx_ready strobe:
- Returns to CAPTURE with count=0, done=0, overflow=0.
- Drops the coincident byte; no wr_en on the next cycle.
REQ-021 rst has priority over clear; clear has priority over rx_ready.
REQ-022 wr_addr and wr_data hold their last values while wr_en=0.

Reset
REQ-023 On rst=1 at posedge clk:
- state=CAPTURE.
- wr_en=0, wr_addr=0, wr_data=0, count=0, done=0, overflow=0.
REQ-024 Reset during an in-flight write (rx_ready in the previous cycle) cancels that write; wr_en=0 in the cycle following reset.

Configuration
REQ-025 Macro RX_RAM_WRITER_TERM_EN, when defined:
- A rx_data of 0 received in CAPTURE is written like any other byte and counted.
- The FSM enters TERM with done=1 in the cycle of that write.
- This matches the NUL-terminated ROM strings sent by the transmitter side.
REQ-026 When RX_RAM_WRITER_TERM_EN is undefined:
- State TERM is unreachable.
- Zero bytes are stored as ordinary data.
- Only FULL ends capture.

Structure
REQ-027 Package rx_ram_writer_pkg holds:
- the state enumeration (CAPTURE, TERM, FULL);
- the terminator byte constant (0).
REQ-028 No sub-module: the RAM is external and driven through wr_en/wr_addr/wr_data; FSM and counter are in one module.

Verification
REQ-029 Bytes 0x48,0x69 strobed 4 cycles apart -> wr_en pulses at addr 0 then 1, data 0x48 then 0x69, each 1 cycle after its strobe; count=2, done=0.
REQ-030 TERM_EN defined, bytes 0x41,0x00,0x42 -> writes 0x41@0 and 0x00@1, done=1, count=2; 0x42 not written, overflow=0.
REQ-031 TERM_EN undefined, ADDR_WIDTH=2, six bytes 0x10..0x15 -> writes 0x10..0x13 @0..3, done=1 with fourth write, count=4; 0x14 sets overflow=1, no further wr_en.
REQ-032 clear coincident with the strobe of byte 0x55 in CAPTURE after 3 bytes -> count=0, no wr_en next cycle; next byte 0x66 written @0.
REQ-033 rst asserted one cycle after a strobe -> wr_en stays 0, all outputs at reset values; subsequent byte written @0.
REQ-034 End-to-end: uart_tx fed from rom/rom_fetcher at CLK_FREQ=38400, BAUDRATE=9600, through uart_rx into this block -> RAM contents match ROM contents through the first 0x00, and done=1.
